// File: rtl/ex_hazard_ctrl_if.sv
// Hazard-controller bundle: ID-stage hazard fields and pipeline controls in,
// stall/flush/forward controls and performance counters out.
interface ex_hazard_ctrl_if;
    logic        i_id_valid;
    logic [4:0]  i_id_rs1;
    logic [4:0]  i_id_rs2;
    logic        i_id_rs1_used;
    logic        i_id_rs2_used;
    logic [4:0]  i_id_rd;
    logic        i_id_rd_wren;
    logic        i_id_is_load;
    logic        i_ex_br_taken;
    logic        i_mem_ready;
    logic        o_pc_en;
    logic        o_if_id_en;
    logic        o_if_id_flush;
    logic        o_id_ex_flush;
    logic [1:0]  o_fwd_a_sel;
    logic [1:0]  o_fwd_b_sel;
    logic [15:0] o_stall_cnt;
    logic [15:0] o_flush_cnt;

    modport master (
        output i_id_valid, i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
               i_id_rd, i_id_rd_wren, i_id_is_load, i_ex_br_taken, i_mem_ready,
        input  o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_flush,
               o_fwd_a_sel, o_fwd_b_sel, o_stall_cnt, o_flush_cnt
    );

    modport slave (
        input  i_id_valid, i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
               i_id_rd, i_id_rd_wren, i_id_is_load, i_ex_br_taken, i_mem_ready,
        output o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_flush,
               o_fwd_a_sel, o_fwd_b_sel, o_stall_cnt, o_flush_cnt
    );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// Hazard controller for the five-stage RV32I core: shadows EX/MEM/WB register
// fields, selects EX operand forwarding, and drives stall/flush controls.
module ex_hazard_ctrl (
    input  logic            i_clk,
    input  logic            i_rst_n,
    ex_hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {ST_RUN, ST_LDSTALL, ST_FLUSH, ST_FREEZE} pipe_state_e;

    pipe_state_e state;

    logic        vld_p0, vld_p1, vld_p2;
    logic [4:0]  rd_p0, rd_p1, rd_p2;
    logic        wren_p0, wren_p1, wren_p2;
    logic        load_p0, load_p1;
    logic [4:0]  rs1_p0, rs2_p0;
    logic        rs1_used_p0, rs2_used_p0;

    logic        load_use;
    logic        br_flush;
    logic        pc_en, if_id_en, if_id_flush, id_ex_flush;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [15:0] stall_cnt, flush_cnt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // A load sitting in MEM has no data yet, so callers pass mem_ok=0 for it.
    function automatic logic [1:0] fwd_sel(input logic       rs_used,
                                           input logic [4:0] rs,
                                           input logic       mem_ok,
                                           input logic [4:0] mem_rd,
                                           input logic       wb_ok,
                                           input logic [4:0] wb_rd);
        logic [1:0] sel;
        sel = 2'b00;
        if (rs_used && (rs != 5'd0)) begin
            if (mem_ok && (mem_rd == rs))
                sel = 2'b01;
            else if (wb_ok && (wb_rd == rs))
                sel = 2'b10;
        end
        return sel;
    endfunction

    // Pipeline state is re-derived every cycle from shadow state and inputs.
    always_comb begin
        load_use = vld_p0 && load_p0 && wren_p0 && (rd_p0 != 5'd0) && hz.i_id_valid &&
                   ((hz.i_id_rs1_used && (hz.i_id_rs1 == rd_p0)) ||
                    (hz.i_id_rs2_used && (hz.i_id_rs2 == rd_p0)));
        br_flush = hz.i_ex_br_taken && vld_p0;

        if (!hz.i_mem_ready)
            state = ST_FREEZE;
        else if (br_flush)
            state = ST_FLUSH;
        else if (load_use)
            state = ST_LDSTALL;
        else
            state = ST_RUN;
    end

    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        case (state)
            ST_FREEZE: begin
                pc_en    = 1'b0;
                if_id_en = 1'b0;
            end
            ST_FLUSH: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end
            ST_LDSTALL: begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
            default: ;
        endcase

        fwd_a_sel = fwd_sel(vld_p0 && rs1_used_p0, rs1_p0,
                            vld_p1 && wren_p1 && !load_p1, rd_p1,
                            vld_p2 && wren_p2, rd_p2);
        fwd_b_sel = fwd_sel(vld_p0 && rs2_used_p0, rs2_p0,
                            vld_p1 && wren_p1 && !load_p1, rd_p1,
                            vld_p2 && wren_p2, rd_p2);
    end

    // Control: shadow valids and performance counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if ((state == ST_LDSTALL) || (state == ST_FREEZE))
                stall_cnt <= sat_inc(stall_cnt);
            if (state == ST_FLUSH)
                flush_cnt <= sat_inc(flush_cnt);
            if (hz.i_mem_ready) begin
                vld_p2 <= vld_p1;
                vld_p1 <= vld_p0;
                vld_p0 <= hz.i_id_valid && !id_ex_flush;
            end
        end
    end

    // Stage boundaries ID->EX (_p0), EX->MEM (_p1), MEM->WB (_p2); fields are
    // only meaningful while the matching valid is set.
    always_ff @(posedge i_clk) begin
        if (hz.i_mem_ready) begin
            rd_p2       <= rd_p1;
            wren_p2     <= wren_p1;
            rd_p1       <= rd_p0;
            wren_p1     <= wren_p0;
            load_p1     <= load_p0;
            rd_p0       <= hz.i_id_rd;
            wren_p0     <= hz.i_id_rd_wren;
            load_p0     <= hz.i_id_is_load;
            rs1_p0      <= hz.i_id_rs1;
            rs2_p0      <= hz.i_id_rs2;
            rs1_used_p0 <= hz.i_id_rs1_used;
            rs2_used_p0 <= hz.i_id_rs2_used;
        end
    end

    assign hz.o_pc_en       = pc_en;
    assign hz.o_if_id_en    = if_id_en;
    assign hz.o_if_id_flush = if_id_flush;
    assign hz.o_id_ex_flush = id_ex_flush;
    assign hz.o_fwd_a_sel   = fwd_a_sel;
    assign hz.o_fwd_b_sel   = fwd_b_sel;
    assign hz.o_stall_cnt   = stall_cnt;
    assign hz.o_flush_cnt   = flush_cnt;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: cycle-by-cycle vector table plus
// hand-written sequences for counter saturation and asynchronous reset.
module tb_ex_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ex_hazard_ctrl_if hz();

    ex_hazard_ctrl dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .hz      (hz)
    );

    typedef struct {
        logic        idv;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic [4:0]  rd;
        logic        wr;
        logic        ld;
        logic        br;
        logic        rdy;
        logic [3:0]  ctl;   // {pc_en, if_id_en, if_id_flush, id_ex_flush}
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [15:0] sc;
        logic [15:0] fc;
    } vec_t;

    vec_t vt[18];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] ctl_now();
        return {8'h00, hz.o_pc_en, hz.o_if_id_en, hz.o_if_id_flush, hz.o_id_ex_flush,
                hz.o_fwd_a_sel, hz.o_fwd_b_sel};
    endfunction

    task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic wr, input logic ld, input logic br, input logic rdy);
        hz.i_id_valid    = v;
        hz.i_id_rs1      = r1;
        hz.i_id_rs2      = r2;
        hz.i_id_rs1_used = u1;
        hz.i_id_rs2_used = u2;
        hz.i_id_rd       = rd;
        hz.i_id_rd_wren  = wr;
        hz.i_id_is_load  = ld;
        hz.i_ex_br_taken = br;
        hz.i_mem_ready   = rdy;
    endtask

    initial begin
        // LW x5 then dependent ADD x6,x5,x1: one stall, then WB forward.
        vt[0]  = '{1'b1, 5'd2,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 1'b1, 1'b0, 1'b1, 4'b1100, 2'b00, 2'b00, 16'd0, 16'd0};
        vt[1]  = '{1'b1, 5'd5,  5'd1,  1'b1, 1'b1, 5'd6,  1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 2'b00, 2'b00, 16'd0, 16'd0};
        vt[2]  = '{1'b1, 5'd5,  5'd1,  1'b1, 1'b1, 5'd6,  1'b1, 1'b0, 1'b0, 1'b1, 4'b1100, 2'b00, 2'b00, 16'd1, 16'd0};
        vt[3]  = '{1'b1, 5'd1,  5'd2,  1'b1, 1'b1, 5'd3,  1'b1, 1'b0, 1'b0, 1'b1, 4'b1100, 2'b10, 2'b00, 16'd1, 16'd0};
        // ADD x3 then SUB x4,x1,x3: EX/MEM forward on b.
        vt[4]  = '{1'b1, 5'd1,  5'd3,  1'b1, 1'b1, 5'd4,  1'b1, 1'b0, 1'b0, 1'b1, 4'b1100, 2'b00, 2'b00, 16'd1, 16'd0};
        vt[5]  = '{1'b1, 5'd3,  5'd4,  1'b0, 1'b0, 5'd3,  1'b1, 1'b0, 1'b0, 1'b1, 4'b1100, 2'b00, 2'b01, 16'd1, 16'd0};
        // Two LUI x3 writers (rs fields unused), then XOR x8,x3,x0: MEM beats WB.
        vt[6]  = '{1'b1, 5'd3,  5'd4,  1'b0, 1'b0, 5'd3,  1'b1, 1'b0, 1'b0, 1'b1, 4'b1100, 2'b00, 2'b00, 16'd1, 16'd0};
        vt[7]  = '{1'b1, 5'd3,  5'd0,  1'b1, 1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 1'b1, 4'b1100, 2'b00, 2'b00, 16'd1, 16'd0};
        vt[8]  = '{1'b1, 5'd1,  5'd0,  1'b1, 1'b0, 5'd0,  1'b1, 1'b1, 1'b0, 1'b1, 4'b1100, 2'b01, 2'b00, 16'd1, 16'd0};
        // LW x0 in EX with ADD x9,x0,x0 in ID: no hazard.
        vt[9]  = '{1'b1, 5'd0,  5'd0,  1'b1, 1'b1, 5'd9,  1'b1, 1'b0, 1'b0, 1'b1, 4'b1100, 2'b00, 2'b00, 16'd1, 16'd0};
        // LW x10 in EX, ADD x11,x10,x10 in ID and taken branch: flush wins.
        vt[10] = '{1'b1, 5'd1,  5'd0,  1'b1, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1100, 2'b00, 2'b00, 16'd1, 16'd0};
        vt[11] = '{1'b1, 5'd10, 5'd10, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1111, 2'b00, 2'b00, 16'd1, 16'd0};
        // EX now a bubble: no load-use, and a stray taken pulse is ignored.
        vt[12] = '{1'b1, 5'd10, 5'd10, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1100, 2'b00, 2'b00, 16'd1, 16'd1};
        // Taken branch held through a 3-cycle freeze, serviced on release.
        vt[13] = '{1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 2'b10, 2'b10, 16'd1, 16'd1};
        vt[14] = '{1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 2'b10, 2'b10, 16'd2, 16'd1};
        vt[15] = '{1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 2'b10, 2'b10, 16'd3, 16'd1};
        vt[16] = '{1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 2'b10, 2'b10, 16'd4, 16'd1};
        vt[17] = '{1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 4'b1100, 2'b00, 2'b00, 16'd4, 16'd2};

        // Reset state, including enables following i_mem_ready.
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        chk("rst_ctl_ready", ctl_now(), 16'h00C0);
        chk("rst_stall_cnt", hz.o_stall_cnt, 16'h0000);
        chk("rst_flush_cnt", hz.o_flush_cnt, 16'h0000);
        hz.i_mem_ready   = 1'b0;
        hz.i_ex_br_taken = 1'b1;
        #1;
        chk("rst_ctl_frozen", ctl_now(), 16'h0000);
        hz.i_mem_ready   = 1'b1;
        hz.i_ex_br_taken = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            drive(vt[i].idv, vt[i].rs1, vt[i].rs2, vt[i].u1, vt[i].u2, vt[i].rd,
                  vt[i].wr, vt[i].ld, vt[i].br, vt[i].rdy);
            @(negedge clk);
            chk($sformatf("vec%0d_ctl", i), ctl_now(), {8'h00, vt[i].ctl, vt[i].fa, vt[i].fb});
            chk($sformatf("vec%0d_stall_cnt", i), hz.o_stall_cnt, vt[i].sc);
            chk($sformatf("vec%0d_flush_cnt", i), hz.o_flush_cnt, vt[i].fc);
            @(posedge clk);
            #1;
        end

        // Drive the stall counter to 16'hFFFE by freezing, then past the top.
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (65530) @(posedge clk);
        #1;
        chk("sat_preload", hz.o_stall_cnt, 16'hFFFE);
        repeat (3) @(posedge clk);
        #1;
        chk("sat_hold", hz.o_stall_cnt, 16'hFFFF);
        chk("sat_flush_cnt", hz.o_flush_cnt, 16'd2);
        chk("sat_frozen_ctl", ctl_now(), 16'h0000);

        // Asynchronous reset mid-cycle clears counters at once.
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_stall_cnt", hz.o_stall_cnt, 16'h0000);
        chk("arst_flush_cnt", hz.o_flush_cnt, 16'h0000);
        chk("arst_ctl_frozen", ctl_now(), 16'h0000);
        hz.i_mem_ready = 1'b1;
        #1;
        chk("arst_ctl_ready", ctl_now(), 16'h00C0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset during a load-use stall discards it.
        drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        chk("ldstall_before_rst", ctl_now(), 16'h0010);
        rst_n = 1'b0;
        #1;
        chk("ldstall_dropped_in_rst", ctl_now(), 16'h00C0);
        #1;
        rst_n = 1'b1;
        #1;
        chk("run_after_rst", ctl_now(), 16'h00C0);
        @(posedge clk);
        #1;
        chk("stall_cnt_after_rst", hz.o_stall_cnt, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
